keypad_matrix_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 64 ++++++
 rtl/key_debounce_counter.sv | 32 +++
 rtl/keypad_matrix_scanner.sv | 170 +++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix scanner.
// Contents: FSM state encoding, 4-bit key codes, the row/column-to-code map,
// a priority decoder for one sensed row, and the digit one-hot helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] K0     = 4'd0;
  localparam logic [3:0] K1     = 4'd1;
  localparam logic [3:0] K2     = 4'd2;
  localparam logic [3:0] K3     = 4'd3;
  localparam logic [3:0] K4     = 4'd4;
  localparam logic [3:0] K5     = 4'd5;
  localparam logic [3:0] K6     = 4'd6;
  localparam logic [3:0] K7     = 4'd7;
  localparam logic [3:0] K8     = 4'd8;
  localparam logic [3:0] K9     = 4'd9;
  localparam logic [3:0] KSTART = 4'd10;
  localparam logic [3:0] KSTOP  = 4'd11;
  localparam logic [3:0] KCLEAR = 4'd12;
  localparam logic [3:0] KNONE  = 4'd15;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = K1;
      4'b00_01: code = K2;
      4'b00_10: code = K3;
      4'b00_11: code = KSTART;
      4'b01_00: code = K4;
      4'b01_01: code = K5;
      4'b01_10: code = K6;
      4'b01_11: code = KSTOP;
      4'b10_00: code = K7;
      4'b10_01: code = K8;
      4'b10_10: code = K9;
      4'b10_11: code = KCLEAR;
      4'b11_01: code = K0;
      default:  code = KNONE;
    endcase
    return code;
  endfunction

  // Walk from the highest column down so the lowest mapped low column wins;
  // unmapped positions never override.
  function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [3:0] col_n);
    logic [3:0] code;
    code = KNONE;
    for (int c = 3; c >= 0; c--) begin
      if (!col_n[c] && key_map(row, 2'(c)) != KNONE) code = key_map(row, 2'(c));
    end
    return code;
  endfunction

  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    return (code <= K9) ? (10'd1 << code) : 10'd0;
  endfunction

endpackage

// File: rtl/key_debounce_counter.sv
// Saturating stability counter used for both press and release debounce.
// Ports: clock, reset (sync, active-high), clr_i (clear to zero, wins over
// increment), inc_i (count one stable sample), tc_o (count is one short of
// DEBOUNCE_CYCLES, so the next stable sample completes the debounce).
module key_debounce_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (inc_i && cnt_q != CW'(DEBOUNCE_CYCLES)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 membrane keypad scanner with press/release debounce.
// Ports: clock, reset (sync, active-high); col_n column sense (active-low);
// row_n row drive (active-low, one-cold); keypad one-hot digit; startn,
// stopn, clearn active-low command strobes; key_valid while a key is held.
//
// state       | meaning
// SCAN        | walk rows, look for any mapped key on the sampled row
// DEB_PRESS   | row held, counting stable samples of the latched key
// HELD        | key accepted, outputs asserted
// DEB_RELEASE | outputs still asserted, counting stable all-released samples
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       clearn,
  output logic       key_valid
);

  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_RELOAD = SW'(SCAN_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    sync1_q, sync2_q;
  // Each synchronised sample carries the row that was driven when it was
  // taken, since the scan moves on while the sample is still in flight.
  logic [1:0]    tag1_q, tag2_q;
  logic [9:0]    keypad_q, keypad_d;
  logic          startn_q, startn_d, stopn_q, stopn_d, clearn_q, clearn_d;
  logic          valid_q, valid_d;
  logic          cnt_clr, cnt_inc, cnt_tc;
  logic [3:0]    sample;
  logic          on_row;

  key_debounce_counter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock (clock),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  assign sample = key_decode(tag2_q, sync2_q);
  assign on_row = (tag2_q == row_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    code_d     = code_q;
    keypad_d   = keypad_q;
    startn_d   = startn_q;
    stopn_d    = stopn_q;
    clearn_d   = clearn_q;
    valid_d    = valid_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      SCAN: begin
        if (sample != KNONE) begin
          code_d     = sample;
          row_d      = tag2_q;
          scan_cnt_d = SCAN_RELOAD;
          cnt_clr    = 1'b1;
          state_d    = DEB_PRESS;
        end else if (scan_cnt_q == '0) begin
          row_d      = row_q + 2'd1;
          scan_cnt_d = SCAN_RELOAD;
        end else begin
          scan_cnt_d = scan_cnt_q - 1'b1;
        end
      end
      DEB_PRESS: begin
        // Samples still in flight from rows scanned after detection are skipped.
        if (on_row) begin
          if (sample == code_q) begin
            cnt_inc = 1'b1;
            if (cnt_tc) begin
              state_d  = HELD;
              keypad_d = digit_onehot(code_q);
              startn_d = (code_q != KSTART);
              stopn_d  = (code_q != KSTOP);
              clearn_d = (code_q != KCLEAR);
              valid_d  = 1'b1;
            end
          end else begin
            cnt_clr    = 1'b1;
            scan_cnt_d = SCAN_RELOAD;
            state_d    = SCAN;
          end
        end
      end
      HELD: begin
        if (sample == KNONE) begin
          cnt_clr = 1'b1;
          state_d = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (sample != KNONE) begin
          state_d = HELD;
        end else if (cnt_tc) begin
          cnt_clr    = 1'b1;
          keypad_d   = '0;
          startn_d   = 1'b1;
          stopn_d    = 1'b1;
          clearn_d   = 1'b1;
          valid_d    = 1'b0;
          row_d      = row_q + 2'd1;
          scan_cnt_d = SCAN_RELOAD;
          state_d    = SCAN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      scan_cnt_q <= SCAN_RELOAD;
      code_q     <= KNONE;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      tag1_q     <= 2'd0;
      tag2_q     <= 2'd0;
      keypad_q   <= '0;
      startn_q   <= 1'b1;
      stopn_q    <= 1'b1;
      clearn_q   <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      scan_cnt_q <= scan_cnt_d;
      code_q     <= code_d;
      sync1_q    <= col_n;
      sync2_q    <= sync1_q;
      tag1_q     <= row_q;
      tag2_q     <= tag1_q;
      keypad_q   <= keypad_d;
      startn_q   <= startn_d;
      stopn_q    <= stopn_d;
      clearn_q   <= clearn_d;
      valid_q    <= valid_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_q);
  assign keypad    = keypad_q;
  assign startn    = startn_q;
  assign stopn     = stopn_q;
  assign clearn    = clearn_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
module tb_keypad_matrix_scanner;

  localparam int DEB       = 4;
  localparam int SYNC      = 2;
  localparam int REL_LAT   = DEB + 1 + SYNC;  // release to deassert
  // Scan wait + debounce + synchroniser, plus two samples from rows scanned
  // after the key's row that are discarded once the row is held.
  localparam int PRESS_MAX = 4 + DEB + SYNC + 2;

  localparam int P_START = 3;
  localparam int P_D4    = 4;
  localparam int P_D5    = 5;
  localparam int P_D7    = 8;
  localparam int P_CLEAR = 11;
  localparam int P_D0    = 13;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, key_valid;
  logic [15:0] pressed;

  int errors = 0;
  int checks = 0;

  keypad_matrix_scanner #(.SCAN_CYCLES(1), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock     (clock),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .keypad    (keypad),
    .startn    (startn),
    .stopn     (stopn),
    .clearn    (clearn),
    .key_valid (key_valid)
  );

  always #5 clock = ~clock;

  // Membrane model: a pressed key shorts its row to its column.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [5];
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    pressed = '0;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (row_n !== 4'b1110 || keypad !== 10'd0 || {startn, stopn, clearn} !== 3'b111 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: row_n=%b keypad=%b s/s/c=%b valid=%b, required 1110 0 111 0",
               row_n, keypad, {startn, stopn, clearn}, key_valid);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (row_n !== exp_rows[i] || keypad !== 10'd0 || {startn, stopn, clearn} !== 3'b111 || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_scan[%0d]: row_n=%b keypad=%b s/s/c=%b, required row_n=%b idle", i, row_n, keypad,
                 {startn, stopn, clearn}, exp_rows[i]);
      end
    end
  endtask

  task automatic test_digit_hold();
    logic [9:0] exp;
    logic [9:0] exp_now;
    int lat;
    int rises;
    logic was_on;
    exp = 10'b0000010000;
    for (int i = 0; i < 8 && row_n !== 4'b1101; i++) step();
    pressed[P_D4] = 1'b1;
    lat = 0;
    while (keypad !== exp && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (keypad !== exp || lat > 10) begin
      errors++;
      $display("FAIL d4_press: keypad=%b after %0d cycles, required %b within 10", keypad, lat, exp);
    end
    was_on = (keypad === exp);
    rises = was_on ? 1 : 0;
    for (int i = lat; i < 100; i++) begin
      step();
      checks++;
      if (keypad !== exp || key_valid !== 1'b1 || {startn, stopn, clearn} !== 3'b111) begin
        errors++;
        $display("FAIL d4_hold: keypad=%b valid=%b, required %b valid=1", keypad, key_valid, exp);
      end
      if (!was_on && keypad === exp) rises++;
      was_on = (keypad === exp);
    end
    pressed[P_D4] = 1'b0;
    for (int i = 1; i <= REL_LAT; i++) begin
      step();
      exp_now = (i < REL_LAT) ? exp : 10'd0;
      checks++;
      if (keypad !== exp_now) begin
        errors++;
        $display("FAIL d4_release[%0d]: keypad=%b, required %b", i, keypad, exp_now);
      end
      if (!was_on && keypad === exp) rises++;
      was_on = (keypad === exp);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL d4_valid_off: key_valid=%b, required 0", key_valid);
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL d4_single_edge: rising edges=%0d, required 1", rises);
    end
  endtask

  task automatic test_chatter();
    logic pat [6];
    logic [9:0] exp;
    int rises;
    logic was_on;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp = 10'b0000100000;
    for (int i = 0; i < 6; i++) begin
      pressed[P_D5] = pat[i];
      step();
      checks++;
      if (keypad !== 10'd0) begin
        errors++;
        $display("FAIL chatter_quiet[%0d]: keypad=%b, required 0", i, keypad);
      end
    end
    pressed[P_D5] = 1'b1;
    rises = 0;
    was_on = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!was_on && keypad === exp) rises++;
      was_on = (keypad === exp);
      checks++;
      if (keypad !== 10'd0 && keypad !== exp) begin
        errors++;
        $display("FAIL chatter_value[%0d]: keypad=%b, required 0 or %b", i, keypad, exp);
      end
    end
    checks++;
    if (rises != 1 || keypad !== exp) begin
      errors++;
      $display("FAIL chatter_accept: rises=%0d keypad=%b, required 1 rise and %b", rises, keypad, exp);
    end
    pressed[P_D5] = 1'b0;
    repeat (REL_LAT) step();
    checks++;
    if (keypad !== 10'd0) begin
      errors++;
      $display("FAIL chatter_release: keypad=%b, required 0", keypad);
    end
  endtask

  task automatic test_start_long();
    int lat;
    int falls;
    logic was_low;
    pressed[P_START] = 1'b1;
    lat = 0;
    while (startn !== 1'b0 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (startn !== 1'b0 || lat > PRESS_MAX) begin
      errors++;
      $display("FAIL start_press: startn=%b after %0d cycles, required 0 within %0d", startn, lat, PRESS_MAX);
    end
    falls = (startn === 1'b0) ? 1 : 0;
    was_low = (startn === 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!was_low && startn === 1'b0) falls++;
      was_low = (startn === 1'b0);
      checks++;
      if ({startn, stopn, clearn} !== 3'b011 || keypad !== 10'd0 || key_valid !== 1'b1) begin
        errors++;
        $display("FAIL start_hold[%0d]: s/s/c=%b keypad=%b valid=%b, required 011 0 1", i,
                 {startn, stopn, clearn}, keypad, key_valid);
      end
    end
    checks++;
    if (falls != 1) begin
      errors++;
      $display("FAIL start_single: assertions=%0d, required 1", falls);
    end
    pressed[P_START] = 1'b0;
    repeat (REL_LAT) step();
    checks++;
    if (startn !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_release: startn=%b valid=%b, required 1 0", startn, key_valid);
    end
  endtask

  task automatic test_clear_then_zero();
    int lat;
    logic clr_exp;
    pressed[P_CLEAR] = 1'b1;
    lat = 0;
    while (clearn !== 1'b0 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (clearn !== 1'b0 || lat > PRESS_MAX) begin
      errors++;
      $display("FAIL clear_press: clearn=%b after %0d cycles, required 0 within %0d", clearn, lat, PRESS_MAX);
    end
    pressed[P_D0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (clearn !== 1'b0 || keypad !== 10'd0 || {startn, stopn} !== 2'b11) begin
        errors++;
        $display("FAIL clear_masks_zero[%0d]: clearn=%b keypad=%b, required 0 and 0", i, clearn, keypad);
      end
    end
    pressed[P_CLEAR] = 1'b0;
    for (int i = 1; i <= REL_LAT; i++) begin
      step();
      clr_exp = (i < REL_LAT) ? 1'b0 : 1'b1;
      checks++;
      if (clearn !== clr_exp || keypad !== 10'd0) begin
        errors++;
        $display("FAIL clear_release[%0d]: clearn=%b keypad=%b, required %b and 0", i, clearn, keypad, clr_exp);
      end
    end
    lat = 0;
    while (keypad !== 10'b0000000001 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (keypad !== 10'b0000000001 || lat > PRESS_MAX) begin
      errors++;
      $display("FAIL zero_accept: keypad=%b after %0d cycles, required 0000000001 within %0d", keypad, lat,
               PRESS_MAX);
    end
    pressed[P_D0] = 1'b0;
    repeat (REL_LAT) step();
    checks++;
    if (keypad !== 10'd0) begin
      errors++;
      $display("FAIL zero_release: keypad=%b, required 0", keypad);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp;
    int lat;
    exp = 10'b0010000000;
    pressed[P_D7] = 1'b1;
    lat = 0;
    while (keypad !== exp && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (keypad !== exp) begin
      errors++;
      $display("FAIL d7_press: keypad=%b, required %b", keypad, exp);
    end
    repeat (5) step();
    reset = 1'b1;
    step();
    checks++;
    if (keypad !== 10'd0 || row_n !== 4'b1110 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: keypad=%b row_n=%b valid=%b, required 0 1110 0", keypad, row_n, key_valid);
    end
    reset = 1'b0;
    lat = 0;
    while (keypad !== exp && lat < 20) begin
      step();
      lat++;
      checks++;
      if (keypad !== 10'd0 && keypad !== exp) begin
        errors++;
        $display("FAIL d7_reaccept_value: keypad=%b, required 0 or %b", keypad, exp);
      end
    end
    checks++;
    if (keypad !== exp || lat < DEB + SYNC + 1 || lat > PRESS_MAX) begin
      errors++;
      $display("FAIL d7_reaccept: keypad=%b after %0d cycles, required %b within %0d..%0d", keypad, lat, exp,
               DEB + SYNC + 1, PRESS_MAX);
    end
    pressed[P_D7] = 1'b0;
    repeat (REL_LAT) step();
    checks++;
    if (keypad !== 10'd0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL d7_release: keypad=%b valid=%b, required 0 0", keypad, key_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pressed = '0;
    test_reset();
    test_digit_hold();
    test_chatter();
    test_start_long();
    test_clear_then_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
